// File: rtl/vec_bram_loader.sv
// rtl/vec_bram_loader.sv - load/replay controller in front of a single-port read-first block RAM
//
// Purpose: a load phase writes a valid/ready burst into the RAM from address 0.
// A replay phase streams the stored words back in address order with a last marker.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   load_start, rd_start           start pulses, honoured only in IDLE (load wins)
//   in_valid/in_ready/in_data/in_last      load stream
//   out_valid/out_ready/out_data/out_last  replay stream (out_data is bram_dout)
//   busy                           registered, high whenever not IDLE
//   word_count                     words stored by the last completed load
//   bram_en/bram_we/bram_addr/bram_din/bram_dout   RAM port
module vec_bram_loader #(
    parameter int DEPTH      = 1024,
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  rd_start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [WIDTH-1:0]      bram_din,
    input  logic [WIDTH-1:0]      bram_dout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_READ = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(DEPTH - 1);

    state_t               state_q, state_d;
    // One bit wider than the RAM address so it can equal word_count (up to DEPTH)
    // and serve directly as the "words remaining" comparison during replay.
    logic [CNT_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0] word_count_q, word_count_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 busy_q;

    logic load_hs;
    logic load_end;
    logic rd_issue;
    logic rd_done;

    always_comb begin
        load_hs  = (state_q == S_LOAD) && in_valid;
        load_end = load_hs && (in_last || (addr_q == LAST_ADDR));
        // A new read may issue only when the output register is free or being
        // drained this cycle; otherwise the RAM is left idle so its output holds.
        rd_issue = (state_q == S_READ) && (addr_q < word_count_q) &&
                   (!out_valid_q || out_ready);
        // The final word carries out_last and no further read can be pending.
        rd_done  = (state_q == S_READ) && out_valid_q && out_ready && out_last_q;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d = S_LOAD;
                end else if (rd_start && (word_count_q != '0)) begin
                    state_d = S_READ;
                end
            end
            S_LOAD: begin
                if (load_end) begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (rd_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = addr_q[ADDR_WIDTH-1:0];
        bram_din  = in_data;
        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                bram_en  = in_valid;
                bram_we  = in_valid;
            end
            S_READ: begin
                bram_en = rd_issue;
            end
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        addr_d       = addr_q;
        word_count_d = word_count_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;

        if ((state_q == S_IDLE) && (state_d != S_IDLE)) begin
            addr_d = '0;
        end

        if (load_hs) begin
            addr_d = addr_q + ONE;
        end
        if (load_end) begin
            word_count_d = addr_q + ONE;
        end

        // Read data appears one cycle after issue, so valid/last follow the issue.
        if (rd_issue) begin
            addr_d      = addr_q + ONE;
            out_valid_d = 1'b1;
            out_last_d  = (addr_q == (word_count_q - ONE));
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            word_count_q <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_data   = bram_dout;
    assign busy       = busy_q;
    assign word_count = word_count_q;

endmodule
